fpu_req_master: RTL
===================

# fpu_req_master

Caller-side initiator for the FPU operation controllers' four-phase `Data_valid`/`Dataout_valid` handshake, the same interface `Mul_cntrl` responds on.
- Accepts operand pairs plus mode from an upstream valid/ready stream into a small FIFO.
- Issues one operation at a time to the controller.
- Returns each result with its exception code in issue order through a one-entry output buffer.
- Replaces bench-level procedural driving once the FPU is embedded in a datapath.

## Interface
Parameters:
- DEPTH, 4: operand FIFO depth, power of 2, ≥2.
- TIMEOUT, 255: max cycles in REQ without acknowledge; only used with `FPU_REQ_TIMEOUT_EN`.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RSTn  in  1  asynchronous active-low reset
- In_valid  in  1  upstream operand pair valid
- In_ready  out  1  FIFO not full
- In_data1  in  32  operand 1, IEEE-754 single
- In_data2  in  32  operand 2, IEEE-754 single
- In_mode  in  3  operation mode
- Datain1  out  32  to controller, operand 1
- Datain2  out  32  to controller, operand 2
- Mode  out  3  to controller, mode
- Data_valid  out  1  to controller, request
- Dataout  in  32  from controller, result
- Dataout_valid  in  1  from controller, acknowledge
- Exc  in  3  from controller, exception code
- Res_valid  out  1  result buffer full
- Res_ready  in  1  downstream consumes result
- Res_data  out  32  result
- Res_exc  out  3  exception code
- Res_timeout  out  1  result produced by timeout abort
- Busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
FSM states:
- IDLE: FIFO has an entry (head) and Res_valid=0 and Dataout_valid=0 → REQ. On that edge, register head into Datain1/Datain2/Mode and set Data_valid=1.
- REQ: Data_valid held 1; Datain1/Datain2/Mode held stable. When Dataout_valid=1 is sampled:
  - capture Dataout/Exc into Res_data/Res_exc, Res_timeout=0, Res_valid=1;
  - pop FIFO, Data_valid=0 → RELEASE.
- RELEASE: Data_valid=0; wait for Dataout_valid=0 sampled → IDLE.
- ABORT (timeout only): entered from REQ when the wait counter reaches TIMEOUT.
  - Data_valid=0, pop FIFO.
  - Result: Res_data=32'h7FC00000, Res_exc=3'b011 (NaN), Res_timeout=1.
  - Then behaves as RELEASE.

Handshake and buffer rules:
- FIFO push when In_valid && In_ready; In_ready = !full, combinational from the count.
- Push and pop in the same cycle are both honoured; count unchanged.
- A push while full is ignored.
- Result buffer clears on Res_valid && Res_ready. A new result may load on the same edge as the clear.
- Data_valid never rises while Dataout_valid=1; a stuck acknowledge stalls in IDLE.
- Datain1/Datain2/Mode keep their last value outside REQ.

Reset:
- All outputs 0, state IDLE, FIFO empty, wait counter 0.
- In_ready becomes 1 when RSTn deasserts.
- Reset mid-REQ drops Data_valid asynchronously; the in-flight operation is discarded.

## Timing
- Data_valid rises 1 cycle after the edge where the IDLE→REQ conditions are true.
- Push to Data_valid high with an empty FIFO: 2 cycles (push edge, then issue edge).
- Res_valid rises on the edge that samples Dataout_valid=1.
- Minimum issue-to-issue spacing: 3 cycles (REQ, RELEASE, IDLE), plus responder latency.
- Wait counter:
  - 8 bits wide (sized by $clog2(TIMEOUT+1)); cleared entering REQ; increments each REQ cycle.
  - Abort on the edge where the count equals TIMEOUT. Data_valid is therefore high for exactly TIMEOUT cycles.

## Configuration
- `FPU_REQ_TIMEOUT_EN` defined: wait counter and ABORT state are compiled in.
- Not defined: REQ waits indefinitely, Res_timeout is tied 0, and the ABORT state does not exist.

## Structure
- Package fpu_req_pkg holds:
  - state enum {IDLE, REQ, RELEASE, ABORT};
  - QNAN = 32'h7FC00000;
  - EXC_NAN = 3'b011, EXC_INF = 3'b100.
- Sub-module fpu_req_fifo: synchronous FIFO, 67-bit entries {mode, data1, data2}, DEPTH entries, full/empty/count outputs, async active-low reset.

## Test plan
- Single op: push 0x40300000, 0x40B00000, mode 0; responder acks 3 cycles after Data_valid with 0x41720000, Exc 000 → Res_data 0x41720000, Res_exc 000, Res_timeout 0; Data_valid high 4 cycles.
- Fill: 5 consecutive pushes with no ack → In_ready low after the 4th, 5th dropped; after acks, 4 results return in push order.
- Backpressure: Res_ready held 0 after the first result → Data_valid stays 0 with FIFO non-empty; next request starts 1 cycle after Res_ready pulses.
- Stuck acknowledge: Dataout_valid=1 before the first push → Data_valid stays 0 until Dataout_valid falls, then rises 1 cycle later.
- Timeout (macro on, TIMEOUT=255): no ack → Data_valid high 255 cycles, then Res_data 0x7FC00000, Res_exc 011, Res_timeout 1.
- Reset in REQ: RSTn low → Data_valid, Res_valid, Busy 0 immediately; FIFO empty; In_ready 1 after release.

Source files
------------

// File: rtl/fpu_req_pkg.sv
// Shared types and constants for the FPU request master.
// The optional timeout/abort path is enabled with the FPU_REQ_TIMEOUT_EN macro.
package fpu_req_pkg;

    // Request master states; ABORT is only reachable when the timeout is compiled in
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } state_t;

    // Result substituted when an operation is abandoned
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [2:0]  EXC_NAN = 3'b011;
    localparam logic [2:0]  EXC_INF = 3'b100;

    // One queued operation: {mode, data1, data2}
    typedef struct packed {
        logic [2:0]  mode;
        logic [31:0] data1;
        logic [31:0] data2;
    } op_t;

    localparam int ENTRY_W = $bits(op_t);

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous operand FIFO for the FPU request master.
// DEPTH must be a power of two so the pointers wrap naturally.
module fpu_req_fifo
    import fpu_req_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO and a pop from an empty one are both ignored
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    assign full  = (cnt_q == (PTR_W + 1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rptr_q];

    // Next-state for storage, pointers and occupancy; push+pop keeps count
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fpu_req_master.sv
// Caller-side initiator for the FPU controllers' four-phase
// Data_valid/Dataout_valid handshake. Operands queue in a FIFO, one
// operation is in flight at a time, results return in issue order through
// a one-entry buffer.
// Define FPU_REQ_TIMEOUT_EN to compile in the REQ wait counter and ABORT state.
//
// Handshakes: upstream transfers when In_valid && In_ready on a rising edge;
// downstream consumes when Res_valid && Res_ready on a rising edge; valid is
// never withdrawn by this block before the transfer completes.
module fpu_req_master
    import fpu_req_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [31:0] In_data1,
    input  logic [31:0] In_data2,
    input  logic [2:0]  In_mode,
    output logic [31:0] Datain1,
    output logic [31:0] Datain2,
    output logic [2:0]  Mode,
    output logic        Data_valid,
    input  logic [31:0] Dataout,
    input  logic        Dataout_valid,
    input  logic [2:0]  Exc,
    output logic        Res_valid,
    input  logic        Res_ready,
    output logic [31:0] Res_data,
    output logic [2:0]  Res_exc,
    output logic        Res_timeout,
    output logic        Busy,
    output logic [1:0]  dbg_state
);

    state_t      state_q, state_d;
    logic        dv_q, dv_d;
    logic [31:0] din1_q, din1_d;
    logic [31:0] din2_q, din2_d;
    logic [2:0]  mode_q, mode_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_data_q, res_data_d;
    logic [2:0]  res_exc_q, res_exc_d;

`ifdef FPU_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             res_to_q, res_to_d;
`endif

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [ENTRY_W-1:0]     fifo_rdata;
    op_t                    head;
    op_t                    in_op;

    // In_ready is held low while reset is asserted so nothing is accepted then
    assign In_ready  = RSTn && !fifo_full;
    assign fifo_push = In_valid && In_ready;

    assign in_op.mode  = In_mode;
    assign in_op.data1 = In_data1;
    assign in_op.data2 = In_data2;
    assign head        = op_t'(fifo_rdata);

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTn),
        .push  (fifo_push),
        .wdata (in_op),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign Datain1    = din1_q;
    assign Datain2    = din2_q;
    assign Mode       = mode_q;
    assign Data_valid = dv_q;
    assign Res_valid  = res_valid_q;
    assign Res_data   = res_data_q;
    assign Res_exc    = res_exc_q;
    assign Busy       = (state_q != IDLE) || (fifo_count != '0);
    assign dbg_state  = state_q;

`ifdef FPU_REQ_TIMEOUT_EN
    assign Res_timeout = res_to_q;
`else
    assign Res_timeout = 1'b0;
`endif

    // Next-state and register updates for the request FSM and result buffer
    always_comb begin
        state_d     = state_q;
        dv_d        = dv_q;
        din1_d      = din1_q;
        din2_d      = din2_q;
        mode_d      = mode_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_exc_d   = res_exc_q;
`ifdef FPU_REQ_TIMEOUT_EN
        wcnt_d      = wcnt_q;
        res_to_d    = res_to_q;
`endif
        fifo_pop    = 1'b0;

        // Consumer drain; a result loaded below on the same edge overrides it
        if (res_valid_q && Res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Issue only into an empty result buffer and a released responder
                if (!fifo_empty && !res_valid_q && !Dataout_valid) begin
                    state_d = REQ;
                    dv_d    = 1'b1;
                    din1_d  = head.data1;
                    din2_d  = head.data2;
                    mode_d  = head.mode;
`ifdef FPU_REQ_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                end
            end
            REQ: begin
`ifdef FPU_REQ_TIMEOUT_EN
                wcnt_d = wcnt_q + 1'b1;
`endif
                // An acknowledge on the final timeout cycle still wins
                if (Dataout_valid) begin
                    state_d     = RELEASE;
                    dv_d        = 1'b0;
                    fifo_pop    = 1'b1;
                    res_valid_d = 1'b1;
                    res_data_d  = Dataout;
                    res_exc_d   = Exc;
`ifdef FPU_REQ_TIMEOUT_EN
                    res_to_d    = 1'b0;
                end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = ABORT;
                    dv_d        = 1'b0;
                    fifo_pop    = 1'b1;
                    res_valid_d = 1'b1;
                    res_data_d  = QNAN;
                    res_exc_d   = EXC_NAN;
                    res_to_d    = 1'b1;
`endif
                end
            end
`ifdef FPU_REQ_TIMEOUT_EN
            RELEASE, ABORT: begin
`else
            RELEASE: begin
`endif
                if (!Dataout_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                dv_d    = 1'b0;
            end
        endcase
    end

    // State registers; reset drops the request immediately
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            dv_q        <= 1'b0;
            din1_q      <= '0;
            din2_q      <= '0;
            mode_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_exc_q   <= '0;
`ifdef FPU_REQ_TIMEOUT_EN
            wcnt_q      <= '0;
            res_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dv_q        <= dv_d;
            din1_q      <= din1_d;
            din2_q      <= din2_d;
            mode_q      <= mode_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_exc_q   <= res_exc_d;
`ifdef FPU_REQ_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
            res_to_q    <= res_to_d;
`endif
        end
    end

endmodule
